ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter; the opposite direction of the keyboard receive path.
- Sends one command byte to the keyboard (e.g. 0xED LED set, 0xFF reset) over the shared open-drain ps2_clk/ps2_data lines.
- Runs the inhibit / request-to-send sequence, shifts data, parity and stop on device-generated clock edges, and checks the device ACK.
- Sits beside ps2_keyboard at top level; the receiver ignores the lines while busy=1.

---
 rtl/ps2_host_tx.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte to a PS/2 device over the shared open-drain clock
// and data lines. The transfer runs in this order:
//    1. Inhibit the bus by holding the clock low.
//    2. Request-to-send: hold data low as well, then release the clock.
//    3. Shift 8 data bits, odd parity and stop on the device clock edges.
//    4. Check the device ACK.
//
// Ports:
//    clk          system clock
//    clr          synchronous reset, active-high
//    ps2_clk      raw PS/2 clock line level (asynchronous)
//    ps2_data     raw PS/2 data line level (asynchronous)
//    tx_data      command byte, sampled only when tx_valid & tx_ready
//    tx_valid     request to send tx_data
//    tx_ready     high while idle
//    ps2_clk_oe   1 = pull clock line low, 0 = release
//    ps2_data_oe  1 = pull data line low, 0 = release
//    busy         transfer in progress
//    done         one-cycle pulse: transfer ended with a valid ACK
//    err          one-cycle pulse: NACK or timeout
//
// Optional build macro PS2_TX_RETRY_EN:
//    When defined, the first NACK or timeout is not reported. The bus is
//    released, the block waits for line idle, and the same byte is sent once
//    more. err pulses only if that retry also fails.
//    When undefined, no retry logic is built.

module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int START_CYCLES   = 50,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int MAX_AB     = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
   localparam int MAX_CYCLES = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES) + 1;

   localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INHIBIT = 3'd1,
      S_START   = 3'd2,
      S_SEND    = 3'd3,
      S_ACK     = 3'd4,
`ifdef PS2_TX_RETRY_EN
      S_RETRY   = 3'd6,
`endif
      S_WAIT    = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;           // phase length / timeout counter
   logic [3:0]    bit_cnt_q, bit_cnt_d;   // falling edges seen in SEND
   logic [9:0]    frame_q, frame_d;       // {stop, parity, data[7:0]} shift register
   logic          out_bit_q, out_bit_d;   // frame bit currently presented on the data line
   logic [7:0]    tx_byte_q, tx_byte_d;   // byte kept intact for a possible resend
   logic          ack_ok_q, ack_ok_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [2:0]    clk_sync_q, clk_sync_d; // [0],[1] synchronizer, [2] edge-detect stage
   logic [2:0]    data_sync_q, data_sync_d;
`ifdef PS2_TX_RETRY_EN
   logic          retry_q, retry_d;
`endif

   logic fe;
   logic line_idle;
   logic fail;

   assign fe        = ~clk_sync_q[1] & clk_sync_q[2];
   assign line_idle = clk_sync_q[1] & data_sync_q[1];

   // State register
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         frame_q     <= '0;
         out_bit_q   <= 1'b0;
         tx_byte_q   <= '0;
         ack_ok_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         // Synchronizers start at the idle-high level so reset never fakes an edge.
         clk_sync_q  <= 3'b111;
         data_sync_q <= 3'b111;
`ifdef PS2_TX_RETRY_EN
         retry_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_q     <= frame_d;
         out_bit_q   <= out_bit_d;
         tx_byte_q   <= tx_byte_d;
         ack_ok_q    <= ack_ok_d;
         done_q      <= done_d;
         err_q       <= err_d;
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
`ifdef PS2_TX_RETRY_EN
         retry_q     <= retry_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_cnt_d   = bit_cnt_q;
      frame_d     = frame_q;
      out_bit_d   = out_bit_q;
      tx_byte_d   = tx_byte_q;
      ack_ok_d    = ack_ok_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      fail        = 1'b0;
      clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
      data_sync_d = {data_sync_q[1:0], ps2_data};
`ifdef PS2_TX_RETRY_EN
      retry_d     = retry_q;
`endif

      case (state_q)
         S_IDLE: begin
`ifdef PS2_TX_RETRY_EN
            retry_d = 1'b0;
`endif
            if (tx_valid) begin
               tx_byte_d = tx_data;
               cnt_d     = '0;
               state_d   = S_INHIBIT;
            end
         end

         S_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               cnt_d   = '0;
               state_d = S_START;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_START: begin
            if (cnt_q == START_LAST) begin
               // Frame is rebuilt from the kept byte, so a resend needs no extra state.
               cnt_d     = '0;
               frame_d   = {1'b1, ~^tx_byte_q, tx_byte_q};
               out_bit_d = 1'b0;
               bit_cnt_d = '0;
               state_d   = S_SEND;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_SEND: begin
            if (fe) begin
               cnt_d     = '0;
               out_bit_d = frame_q[0];
               frame_d   = {1'b0, frame_q[9:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               // The tenth edge presents the stop bit; ACK follows.
               if (bit_cnt_q == 4'd9) begin
                  state_d = S_ACK;
               end
            end else if (cnt_q == TMO_LAST) begin
               fail = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_ACK: begin
            if (fe) begin
               cnt_d    = '0;
               ack_ok_d = ~data_sync_q[1];
               state_d  = S_WAIT;
            end else if (cnt_q == TMO_LAST) begin
               fail = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_WAIT: begin
            if (line_idle) begin
               if (ack_ok_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  fail = 1'b1;
               end
            end else if (fe) begin
               cnt_d = '0;
            end else if (cnt_q == TMO_LAST) begin
               fail = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

`ifdef PS2_TX_RETRY_EN
         S_RETRY: begin
            if (line_idle) begin
               cnt_d   = '0;
               state_d = S_INHIBIT;
            end else if (cnt_q == TMO_LAST) begin
               fail = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif

         default: state_d = S_IDLE;
      endcase

      if (fail) begin
`ifdef PS2_TX_RETRY_EN
         if (!retry_q) begin
            retry_d = 1'b1;
            cnt_d   = '0;
            state_d = S_RETRY;
         end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
         end
`else
         err_d   = 1'b1;
         state_d = S_IDLE;
`endif
      end
   end

   // Outputs: open-drain enables only ever pull low
   always_comb begin
      tx_ready    = (state_q == S_IDLE);
      busy        = (state_q != S_IDLE);
      ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_START);
      ps2_data_oe = (state_q == S_START) || ((state_q == S_SEND) && !out_bit_q);
      done        = done_q;
      err         = err_q;
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int STC  = 4;
   localparam int TMO  = 200;
   localparam int HALF = 8;   // device clock half-period in clk cycles (1/16 rate)
`ifdef PS2_TX_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clr;
   logic       ps2_clk, ps2_data;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
   logic       dev_clk_low, dev_data_low;

   // Open-drain bus with pull-ups
   assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data = ~(ps2_data_oe | dev_data_low);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .START_CYCLES(STC),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .clr(clr),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy(busy),
      .done(done),
      .err(err)
   );

   typedef struct {
      logic [7:0] data;
      int         nacks;     // attempts the device answers with NACK
      logic       par;
      int         frames;
      int         exp_done;
      int         exp_err;
   } vec_t;

   vec_t vecs[5];

   int n_vec = 0;
   int n_bad = 0;
   int n_done, n_err, n_busy_done;

   task automatic tick();
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
      if (done === 1'b1 && busy !== 1'b0) n_busy_done++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Measures the host request, then clocks one frame and gives the ACK slot.
   task automatic dev_frame(input bit ack, output logic [9:0] cap, output int inh,
                            output int st, output logic start_held);
      inh = 0;
      st  = 0;
      cap = '0;
      for (int i = 0; i < 1000 && !ps2_clk_oe; i++) tick();
      for (int i = 0; i < 1000; i++) begin
         if (ps2_clk_oe && !ps2_data_oe) inh++;
         else if (ps2_clk_oe && ps2_data_oe) st++;
         else break;
         tick();
      end
      start_held = ps2_data_oe;
      for (int b = 0; b < 10; b++) begin
         repeat (HALF) tick();
         dev_clk_low = 1'b1;
         repeat (HALF) tick();
         cap[b] = ps2_data;
         dev_clk_low = 1'b0;
      end
      repeat (HALF / 2) tick();
      dev_data_low = ack;
      repeat (HALF / 2) tick();
      dev_clk_low = 1'b1;
      repeat (HALF) tick();
      dev_clk_low = 1'b0;
      if (ack) begin
         repeat (4) tick();
         dev_data_low = 1'b0;
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic [9:0] cap;
      int         inh, st, frames;
      logic       sh;
      bit         fin;
      n_done = 0;
      n_err = 0;
      n_busy_done = 0;
      frames = 0;
      fin = 1'b0;
      tx_data  = v.data;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      while (!fin && frames < 3) begin
         dev_frame(frames >= v.nacks, cap, inh, st, sh);
         frames++;
         check($sformatf("tx%02h_data", v.data), 32'(cap[7:0]), 32'(v.data));
         check($sformatf("tx%02h_parity", v.data), 32'(cap[8]), 32'(v.par));
         check($sformatf("tx%02h_stop", v.data), 32'(cap[9]), 32'd1);
         check($sformatf("tx%02h_inhibit", v.data), 32'(inh), 32'(INH));
         check($sformatf("tx%02h_start", v.data), 32'(st), 32'(STC));
         check($sformatf("tx%02h_start_bit_held", v.data), 32'(sh), 32'd1);
         for (int i = 0; i < 200; i++) begin
            if (done || err) begin
               fin = 1'b1;
               break;
            end
            if (ps2_clk_oe) break;
            tick();
         end
         if (!fin && !ps2_clk_oe) begin
            check($sformatf("tx%02h_outcome_in_time", v.data), 32'd0, 32'd1);
            fin = 1'b1;
         end
      end
      repeat (10) tick();
      check($sformatf("tx%02h_frames", v.data), 32'(frames), 32'(v.frames));
      check($sformatf("tx%02h_done_pulses", v.data), 32'(n_done), 32'(v.exp_done));
      check($sformatf("tx%02h_err_pulses", v.data), 32'(n_err), 32'(v.exp_err));
      check($sformatf("tx%02h_busy_at_done", v.data), 32'(n_busy_done), 32'd0);
      check($sformatf("tx%02h_ready_after", v.data), 32'(tx_ready), 32'd1);
   endtask

   initial begin
      int   cnt;
      int   attempts;
      vec_t vff;

      // data, nacks, parity, frames, done, err
      vecs[0] = '{8'hED, 0, 1'b1, 1, 1, 0};
      vecs[1] = '{8'h00, 0, 1'b1, 1, 1, 0};
      vecs[2] = '{8'h01, 0, 1'b0, 1, 1, 0};
      vecs[3] = '{8'hF4, 1, 1'b0, RETRY ? 2 : 1, RETRY ? 1 : 0, RETRY ? 0 : 1};
      vecs[4] = '{8'h3C, 2, 1'b1, RETRY ? 2 : 1, 0, 1};

      clr = 1'b1;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      dev_clk_low = 1'b0;
      dev_data_low = 1'b0;
      n_done = 0;
      n_err = 0;
      n_busy_done = 0;

      // Reset
      tick();
      tick();
      clr = 1'b0;
      check("reset_tx_ready", 32'(tx_ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("reset_data_oe", 32'(ps2_data_oe), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      repeat (3) tick();

      // Table-driven transfers
      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Device never clocks after release
      n_err = 0;
      tx_data = 8'hAA;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      attempts = RETRY ? 2 : 1;
      for (int a = 0; a < attempts; a++) begin
         for (int i = 0; i < 300 && !ps2_clk_oe; i++) tick();
         for (int i = 0; i < 300 && ps2_clk_oe; i++) tick();
         cnt = 0;
         for (int i = 0; i < 400; i++) begin
            tick();
            cnt++;
            if (err || ps2_clk_oe) break;
         end
         if (a == attempts - 1) begin
            check("timeout_cycles", 32'(cnt), 32'(TMO));
            check("timeout_err", 32'(err), 32'd1);
            check("timeout_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
         end
      end
      repeat (5) tick();
      check("timeout_err_pulses", 32'(n_err), 32'd1);
      check("timeout_ready", 32'(tx_ready), 32'd1);

      // clr mid-frame after bit 4; 0x52 has bit3=0 so data is pulled low there
      tx_data = 8'h52;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      for (int i = 0; i < 300 && ps2_clk_oe; i++) tick();
      for (int b = 0; b < 4; b++) begin
         repeat (HALF) tick();
         dev_clk_low = 1'b1;
         repeat (HALF) tick();
         dev_clk_low = 1'b0;
      end
      tick();
      check("midframe_data_oe_before_clr", 32'(ps2_data_oe), 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("midframe_clr_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("midframe_clr_data_oe", 32'(ps2_data_oe), 32'd0);
      check("midframe_clr_tx_ready", 32'(tx_ready), 32'd1);
      check("midframe_clr_busy", 32'(busy), 32'd0);
      repeat (3) tick();
      vff = '{8'hFF, 0, 1'b1, 1, 1, 0};
      run_vec(vff);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
